// File: rtl/branch_resolve_unit_if.sv
// Interface bundling the EX-stage request and the registered resolution results
// of branch_resolve_unit. The EX pipeline drives it through the master side. The
// resolve unit uses the slave side. clk_i and rst_i stay as plain module ports.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    // Request side, valid during the EX cycle
    logic            valid_i;
    logic            flush_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] operand1_i;
    logic [XLEN-1:0] operand2_i;
    logic [XLEN-1:0] imm_i;
    logic [6:0]      opcode_i;
    logic [2:0]      funct3_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] fetch_pc_i;

    // Result side
    logic            pred_taken_o;
    logic            resolve_valid_o;
    logic            taken_o;
    logic [XLEN-1:0] target_o;
    logic [XLEN-1:0] link_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            mispredict_o;
    logic            misaligned_o;
    logic            illegal_o;

    modport master (
        output valid_i, flush_i, pc_i, operand1_i, operand2_i, imm_i,
               opcode_i, funct3_i, pred_taken_i, fetch_pc_i,
        input  pred_taken_o, resolve_valid_o, taken_o, target_o, link_o,
               redirect_pc_o, mispredict_o, misaligned_o, illegal_o
    );

    modport slave (
        input  valid_i, flush_i, pc_i, operand1_i, operand2_i, imm_i,
               opcode_i, funct3_i, pred_taken_i, fetch_pc_i,
        output pred_taken_o, resolve_valid_o, taken_o, target_o, link_o,
               redirect_pc_o, mispredict_o, misaligned_o, illegal_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage resolution of BRANCH / JAL / JALR.
// The unit computes the direction, the target, the link and the redirect PC. It
// flags mispredicts, misaligned targets and illegal branch funct3 values. Results
// are registered, so a redirect appears one cycle after issue.
// Optional feature macro: BRU_BHT_EN adds a table of 2-bit saturating counters
// that predicts fetch-time direction. Without the macro, prediction is static
// not-taken.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    branch_resolve_unit_if.slave bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_cond;
    logic            w_illegal;
    logic            w_taken;
    logic [XLEN-1:0] w_sum_pc;
    logic [XLEN-1:0] w_sum_rs;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic [XLEN-1:0] w_redirect;
    logic            w_misaligned;
    logic            w_mispredict;
    logic            w_accept;

    logic            r_resolve_valid;
    logic            r_taken;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_link;
    logic [XLEN-1:0] r_redirect;
    logic            r_mispredict;
    logic            r_misaligned;
    logic            r_illegal;

    assign w_is_branch = (bus.opcode_i == OP_BRANCH);
    assign w_is_jal    = (bus.opcode_i == OP_JAL);
    assign w_is_jalr   = (bus.opcode_i == OP_JALR);

    // Branch condition. The reserved funct3 values 010/011 fall to the default and
    // resolve not-taken.
    always_comb begin
        w_cond = 1'b0;
        case (bus.funct3_i)
            3'b000:  w_cond = (bus.operand1_i == bus.operand2_i);
            3'b001:  w_cond = (bus.operand1_i != bus.operand2_i);
            3'b100:  w_cond = ($signed(bus.operand1_i) <  $signed(bus.operand2_i));
            3'b101:  w_cond = ($signed(bus.operand1_i) >= $signed(bus.operand2_i));
            3'b110:  w_cond = (bus.operand1_i <  bus.operand2_i);
            3'b111:  w_cond = (bus.operand1_i >= bus.operand2_i);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_illegal  = w_is_branch & ((bus.funct3_i == 3'b010) | (bus.funct3_i == 3'b011));
    assign w_taken    = w_is_jal | w_is_jalr | (w_is_branch & w_cond);

    // Additions wrap at XLEN bits. JALR clears bit 0 of its sum.
    assign w_sum_pc   = bus.pc_i + bus.imm_i;
    assign w_sum_rs   = bus.operand1_i + bus.imm_i;
    assign w_target   = w_is_jalr ? {w_sum_rs[XLEN-1:1], 1'b0} : w_sum_pc;
    assign w_link     = bus.pc_i + {{(XLEN-3){1'b0}}, 3'b100};
    assign w_redirect = w_taken ? w_target : w_link;

    // A misaligned or illegal result goes to the trap path. In that case the fetch
    // redirect stays quiet.
    assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);
    assign w_mispredict = ~w_misaligned & ~w_illegal &
                          (w_is_branch ? (w_taken != bus.pred_taken_i) : 1'b1);

    assign w_accept = bus.valid_i & ~bus.flush_i & (w_is_branch | w_is_jal | w_is_jalr);

    // Result registers. The flags are pulses. Data outputs hold between resolutions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resolve_valid <= 1'b0;
            r_taken         <= 1'b0;
            r_target        <= '0;
            r_link          <= '0;
            r_redirect      <= '0;
            r_mispredict    <= 1'b0;
            r_misaligned    <= 1'b0;
            r_illegal       <= 1'b0;
        end else if (w_accept) begin
            r_resolve_valid <= 1'b1;
            r_taken         <= w_taken;
            r_target        <= w_target;
            r_link          <= w_link;
            r_redirect      <= w_redirect;
            r_mispredict    <= w_mispredict;
            r_misaligned    <= w_misaligned;
            r_illegal       <= w_illegal;
        end else begin
            r_resolve_valid <= 1'b0;
            r_mispredict    <= 1'b0;
            r_misaligned    <= 1'b0;
            r_illegal       <= 1'b0;
        end
    end

    assign bus.resolve_valid_o = r_resolve_valid;
    assign bus.taken_o         = r_taken;
    assign bus.target_o        = r_target;
    assign bus.link_o          = r_link;
    assign bus.redirect_pc_o   = r_redirect;
    assign bus.mispredict_o    = r_mispredict;
    assign bus.misaligned_o    = r_misaligned;
    assign bus.illegal_o       = r_illegal;

`ifdef BRU_BHT_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic                   w_bht_we;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [IDX_W-1:0]       w_rd_idx;
    logic [BHT_ENTRIES-1:0] w_pred_bits;

    assign w_bht_we = w_accept & w_is_branch & ~w_illegal & ~w_misaligned;
    assign w_wr_idx = bus.pc_i[IDX_W+1:2];
    assign w_rd_idx = bus.fetch_pc_i[IDX_W+1:2];

    // One counter per entry. Each counter keeps its old value during the edge that
    // writes it. So a fetch read of the same index in that cycle sees the old value.
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        logic [1:0] r_cnt;

        // Saturating 2-bit update. The counter resets to weakly not-taken.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt <= 2'b01;
            end else if (w_bht_we && (w_wr_idx == IDX_W'(gi))) begin
                if (w_taken && (r_cnt != 2'b11)) begin
                    r_cnt <= r_cnt + 2'b01;
                end else if (!w_taken && (r_cnt != 2'b00)) begin
                    r_cnt <= r_cnt - 2'b01;
                end
            end
        end

        assign w_pred_bits[gi] = r_cnt[1];
    end

    assign bus.pred_taken_o = w_pred_bits[w_rd_idx];
`else
    // Static not-taken prediction.
    assign bus.pred_taken_o = 1'b0;
`endif

endmodule
